// File: rtl/stack_sequencer.sv
// Command front-end for the register stack: checks depth limits and issues one or two primitive stack ops.
// Optional high-water-mark output enabled by defining STACK_SEQ_HWM_EN.
module stack_sequencer #(
  parameter int STACK_SIZE = 64,
  parameter int DEPTH_W    = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_op,
  input  logic [15:0]        cmd_imm,
  input  logic [15:0]        top_a,
  input  logic [15:0]        top_b,
  output logic [2:0]         stack_op,
  output logic [15:0]        stack_w,
  output logic               stack_clr,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [DEPTH_W-1:0] depth
`ifdef STACK_SEQ_HWM_EN
  ,
  output logic [DEPTH_W-1:0] hwm
`endif
);

  typedef enum logic [1:0] {IDLE, STEP1, STEP2, ERR} state_t;
  typedef enum logic [1:0] {W_ZERO, W_IMM, W_A, W_B} wsel_t;

  state_t             state, state_nxt;
  logic               clr_r, clr_nxt;
  logic [2:0]         op_nxt;
  logic [15:0]        w_nxt, w_sel;
  logic               done_nxt, err_nxt, depth_upd;
  logic [1:0]         code_nxt;
  logic [DEPTH_W-1:0] depth_nxt;
  logic               two_q;
  logic signed [2:0]  delta_q;

  logic               d_legal, d_two, d_clr;
  logic [1:0]         d_min, d_room;
  logic [2:0]         d_op1;
  wsel_t              d_wsel;
  logic signed [2:0]  d_delta;

  function automatic logic underflows(input logic [DEPTH_W-1:0] d, input logic [1:0] min_d);
    return int'(d) < int'(min_d);
  endfunction

  // room = entries the command adds; zero room never overflows
  function automatic logic exceeds(input logic [DEPTH_W-1:0] d, input logic [1:0] room);
    return (int'(d) + int'(room)) > STACK_SIZE;
  endfunction

  always_comb begin
    d_legal = 1'b1;
    d_two   = 1'b0;
    d_clr   = 1'b0;
    d_min   = 2'd0;
    d_room  = 2'd0;
    d_op1   = 3'd0;
    d_wsel  = W_ZERO;
    d_delta = 3'sd0;
    case (cmd_op)
      4'd0:  ;
      4'd1:  begin d_room = 2'd1; d_op1 = 3'd1; d_wsel = W_IMM; d_delta = 3'sd1; end
      4'd2:  begin d_min = 2'd1; d_op1 = 3'd3; d_delta = -3'sd1; end
      4'd3:  begin d_min = 2'd1; d_room = 2'd1; d_op1 = 3'd1; d_wsel = W_A; d_delta = 3'sd1; end
      4'd4:  begin d_min = 2'd2; d_op1 = 3'd5; end
      4'd5:  begin d_min = 2'd2; d_room = 2'd1; d_op1 = 3'd1; d_wsel = W_B; d_delta = 3'sd1; end
      4'd6:  begin d_min = 2'd2; d_op1 = 3'd2; d_wsel = W_A; d_delta = -3'sd1; end
      4'd7:  begin d_min = 2'd2; d_op1 = 3'd4; d_delta = -3'sd2; end
      4'd8:  begin d_min = 2'd2; d_room = 2'd2; d_op1 = 3'd1; d_wsel = W_B; d_two = 1'b1; d_delta = 3'sd2; end
      4'd9:  begin d_min = 2'd2; d_room = 2'd1; d_op1 = 3'd5; d_two = 1'b1; d_delta = 3'sd1; end
      4'd10: begin d_min = 2'd2; d_op1 = 3'd2; d_wsel = W_IMM; d_delta = -3'sd1; end
      4'd11: d_clr = 1'b1;
      default: d_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_sel = 16'h0000;
    case (d_wsel)
      W_IMM:   w_sel = cmd_imm;
      W_A:     w_sel = top_a;
      W_B:     w_sel = top_b;
      default: w_sel = 16'h0000;
    endcase
  end

  always_comb begin
    state_nxt = state;
    op_nxt    = 3'd0;
    w_nxt     = 16'h0000;
    clr_nxt   = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    code_nxt  = err_code;
    depth_upd = 1'b0;
    case (state)
      IDLE: if (cmd_valid) begin
        if (!d_legal) begin
          state_nxt = ERR; err_nxt = 1'b1; code_nxt = 2'd3;
        end else if (underflows(depth, d_min)) begin
          state_nxt = ERR; err_nxt = 1'b1; code_nxt = 2'd1;
        end else if (exceeds(depth, d_room)) begin
          state_nxt = ERR; err_nxt = 1'b1; code_nxt = 2'd2;
        end else begin
          state_nxt = STEP1;
          op_nxt    = d_op1;
          w_nxt     = w_sel;
          clr_nxt   = d_clr;
          done_nxt  = !d_two;
        end
      end
      // Both two-step commands finish with a push of the post-STEP1 second entry
      STEP1: if (two_q) begin
        state_nxt = STEP2; op_nxt = 3'd1; w_nxt = top_b; done_nxt = 1'b1;
      end else begin
        state_nxt = IDLE; depth_upd = 1'b1;
      end
      STEP2: begin state_nxt = IDLE; depth_upd = 1'b1; end
      default: state_nxt = IDLE;
    endcase
  end

  assign depth_nxt = clr_r ? '0 : depth + {{(DEPTH_W-3){delta_q[2]}}, delta_q};
  assign cmd_ready = (state == IDLE);
  assign stack_clr = clr_r | reset;

  // issue stage: registered outputs toward the stack
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      stack_op <= 3'd0;
      stack_w  <= 16'h0000;
      clr_r    <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'd0;
      depth    <= '0;
    end else begin
      state    <= state_nxt;
      stack_op <= op_nxt;
      stack_w  <= w_nxt;
      clr_r    <= clr_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
      err_code <= code_nxt;
      if (depth_upd) depth <= depth_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_valid && state == IDLE) begin
      two_q   <= d_two;
      delta_q <= d_delta;
    end
  end

`ifdef STACK_SEQ_HWM_EN
  always_ff @(posedge clk) begin
    if (reset) hwm <= '0;
    else if (depth_upd) hwm <= clr_r ? '0 : ((depth_nxt > hwm) ? depth_nxt : hwm);
  end
`endif

endmodule
